// File: rtl/sram_frame_reader_pkg.sv
// ---------------------------------------------------------------------------
// sram_frame_reader_pkg : shared frame geometry, SRAM widths and FSM encoding
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sram_frame_reader_pkg;

  localparam int          N_PIXEL_DEF     = 480000;
  localparam int          SRAM_ADDR_W     = 18;
  localparam int          SRAM_DATA_W     = 32;
  localparam int          PIXEL_W         = 8;
  localparam int          PIX_PER_WORD    = SRAM_DATA_W / PIXEL_W;
  localparam int          FIFO_DEPTH_DEF  = 8;
  localparam logic [17:0] FRAME0_BASE_DEF = 18'd0;
  localparam logic [17:0] FRAME1_BASE_DEF = 18'd131072;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_t;

  // Counter width that stays legal when the range collapses to one value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_reader_fifo.sv
// ---------------------------------------------------------------------------
// frame_reader_fifo : synchronous first-word-fall-through FIFO with count
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frame_reader_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wptr] <= i_din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/sram_frame_reader.sv
// ---------------------------------------------------------------------------
// sram_frame_reader : streams a stored grey frame from SRAM as 8-bit pixels
// Optional FRAME_READER_CHECKSUM_EN adds a 16-bit emitted-pixel checksum.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_frame_reader
  import sram_frame_reader_pkg::*;
#(
  parameter int                     N_PIXEL     = N_PIXEL_DEF,
  parameter logic [SRAM_ADDR_W-1:0] FRAME0_BASE = FRAME0_BASE_DEF,
  parameter logic [SRAM_ADDR_W-1:0] FRAME1_BASE = FRAME1_BASE_DEF,
  parameter int                     FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  output logic                   start_ack,
  input  logic                   frame_sel,
  output logic                   done,
  input  logic                   done_ack,
  output logic [SRAM_ADDR_W-1:0] addr,
  output logic                   addr_valid,
  input  logic                   addr_ready,
  input  logic [SRAM_DATA_W-1:0] data,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic [PIXEL_W-1:0]     pixel,
  output logic                   pixel_valid,
  input  logic                   pixel_ready
`ifdef FRAME_READER_CHECKSUM_EN
  ,
  output logic [15:0]            checksum
`endif
);

  localparam int N_WORD = N_PIXEL / PIX_PER_WORD;
  localparam int WCW    = cnt_w(N_WORD);
  localparam int PCW    = cnt_w(N_PIXEL);
  localparam int CW     = $clog2(FIFO_DEPTH + 1);

  rd_state_t              r_state;
  logic [SRAM_ADDR_W-1:0] r_base;
  logic [WCW-1:0]         r_word_cnt;
  logic [PCW-1:0]         r_pix_cnt;
  logic [CW-1:0]          r_outstanding;
  logic [1:0]             r_k;
  logic [PIXEL_W-1:0]     r_pixel;
  logic                   r_pixel_valid;
  logic                   r_start_ack;
  logic                   r_done;

  logic                   w_active;
  logic [CW:0]            w_inflight;
  logic                   w_addr_valid;
  logic                   w_addr_xfer;
  logic                   w_data_take;
  logic                   w_load;
  logic                   w_pop;
  logic                   w_pix_xfer;
  logic                   w_last_word;
  logic                   w_last_pix;
  logic [SRAM_DATA_W-1:0] w_fifo_dout;
  logic [CW-1:0]          w_fifo_count;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;

  assign w_active     = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign w_inflight   = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  // Only request while a FIFO slot is reserved for every word in flight.
  assign w_addr_valid = (r_state == ST_FETCH) && (w_inflight < (CW+1)'(FIFO_DEPTH));
  assign w_addr_xfer  = w_addr_valid & addr_ready;
  assign w_data_take  = w_active & data_valid & (r_outstanding != '0);
  assign w_load       = w_active & ~w_fifo_empty & (~r_pixel_valid | pixel_ready);
  assign w_pop        = w_load & (r_k == 2'd3);
  assign w_pix_xfer   = r_pixel_valid & pixel_ready;
  assign w_last_word  = (r_word_cnt == WCW'(N_WORD - 1));
  assign w_last_pix   = (r_pix_cnt == PCW'(N_PIXEL - 1));

  assign addr        = r_base + SRAM_ADDR_W'(r_word_cnt);
  assign addr_valid  = w_addr_valid;
  assign data_ready  = w_active;
  assign pixel       = r_pixel;
  assign pixel_valid = r_pixel_valid;
  assign start_ack   = r_start_ack;
  assign done        = r_done;

  frame_reader_fifo #(
    .WIDTH (SRAM_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_data_take),
    .i_din   (data),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_word_cnt  <= '0;
      r_pix_cnt   <= '0;
      r_start_ack <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_start_ack <= 1'b0;
      if (w_pix_xfer && !w_last_pix) r_pix_cnt <= r_pix_cnt + PCW'(1);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_FETCH;
            r_start_ack <= 1'b1;
            r_base      <= frame_sel ? FRAME1_BASE : FRAME0_BASE;
            r_word_cnt  <= '0;
            r_pix_cnt   <= '0;
          end
        end
        ST_FETCH: begin
          if (w_addr_xfer) begin
            if (w_last_word) r_state <= ST_DRAIN;
            else             r_word_cnt <= r_word_cnt + WCW'(1);
          end
        end
        ST_DRAIN: begin
          if (w_pix_xfer && w_last_pix) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (done_ack) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_outstanding <= '0;
      r_k           <= '0;
      r_pixel       <= '0;
      r_pixel_valid <= 1'b0;
    end else begin
      case ({w_addr_xfer, w_data_take & ~w_fifo_full})
        2'b10:   r_outstanding <= r_outstanding + CW'(1);
        2'b01:   r_outstanding <= r_outstanding - CW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_load) begin
        r_pixel       <= w_fifo_dout[{r_k, 3'b000} +: PIXEL_W];
        r_pixel_valid <= 1'b1;
        r_k           <= r_k + 2'd1;
      end else if (w_pix_xfer) begin
        r_pixel_valid <= 1'b0;
      end
    end
  end

`ifdef FRAME_READER_CHECKSUM_EN
  logic [15:0] r_checksum;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_checksum <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_checksum <= '0;
    end else if (w_pix_xfer) begin
      r_checksum <= r_checksum + 16'(r_pixel);
    end
  end

  assign checksum = r_checksum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_sram_frame_reader : directed bench with an SRAM read-port model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_frame_reader;

  localparam int NP    = 16;
  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        start_ack;
  logic        frame_sel;
  logic        done;
  logic        done_ack;
  logic [17:0] addr;
  logic        addr_valid;
  logic        addr_ready;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready;
  logic [7:0]  pixel;
  logic        pixel_valid;
  logic        pixel_ready;
`ifdef FRAME_READER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  always #5 clock = ~clock;

  sram_frame_reader #(
    .N_PIXEL    (NP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .start_ack   (start_ack),
    .frame_sel   (frame_sel),
    .done        (done),
    .done_ack    (done_ack),
    .addr        (addr),
    .addr_valid  (addr_valid),
    .addr_ready  (addr_ready),
    .data        (data),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready)
`ifdef FRAME_READER_CHECKSUM_EN
    ,
    .checksum    (checksum)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int dmode = 0;
  int pr_rand = 0;
  int ar_rand = 0;
  int spur = 0;
  int lat_min = 2;
  int lat_max = 2;

  logic [17:0] q_addr[$];
  int          q_due[$];
  logic [17:0] iss_addr[$];
  logic [7:0]  cap_pix[$];
  int          last_pix_cyc;
  int          done_cyc;
  int          ack_cnt;
  int          f_issued;
  int          f_xfer;
  int          first_dcyc;
  int          first_pcyc;
  logic        prev_done;
  logic        prev_stall;
  logic [7:0]  prev_pix;

  function automatic logic [31:0] mk_word(input logic [17:0] a, input int m);
    logic [5:0] s;
    s = a[5:0];
    case (m)
      0:       return {14'd0, a};
      1:       return {s, 2'd3, s, 2'd2, s, 2'd1, s, 2'd0};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [7:0] exp_pix(input logic [17:0] base, input int i, input int m);
    logic [31:0] w;
    w = mk_word(base + 18'(i / 4), m);
    return w[8 * (i % 4) +: 8];
  endfunction

  // SRAM read-port model plus per-cycle stream monitors.
  initial begin
    addr_ready = 1'b0; data = '0; data_valid = 1'b0; pixel_ready = 1'b0;
    prev_done = 1'b0; prev_stall = 1'b0; prev_pix = '0;
    ack_cnt = 0; f_issued = 0; f_xfer = 0; done_cyc = -1; last_pix_cyc = -1;
    first_dcyc = -1; first_pcyc = -1;
    forever begin
      @(negedge clock);
      cyc++;
      #1;
      if (!reset_n) begin
        q_addr.delete(); q_due.delete();
        data_valid = 1'b0; prev_stall = 1'b0; prev_done = 1'b0;
        f_issued = 0; f_xfer = 0;
      end else begin
        addr_ready  = ar_rand != 0 ? ($urandom_range(0, 99) < 80) : 1'b1;
        pixel_ready = pr_rand != 0 ? ($urandom_range(0, 99) >= 30) : 1'b1;
        if (q_addr.size() > 0 && q_due[0] <= cyc) begin
          data_valid = 1'b1; data = mk_word(q_addr[0], dmode);
        end else if (spur != 0 && q_addr.size() == 0 && $urandom_range(0, 3) == 0) begin
          data_valid = 1'b1; data = 32'hDEAD_BEEF;
        end else begin
          data_valid = 1'b0; data = $urandom;
        end
      end
      #1;
      if (reset_n) begin
        if (start_ack) begin
          ack_cnt++; f_issued = 0; f_xfer = 0; first_dcyc = -1; first_pcyc = -1;
        end
        if (prev_stall) begin
          tests++;
          if (pixel_valid !== 1'b1 || pixel !== prev_pix) begin
            fails++;
            $display("FAIL stall_hold: valid=%b pixel=%h, required valid=1 pixel=%h",
                     pixel_valid, pixel, prev_pix);
          end
        end
        prev_stall = pixel_valid & ~pixel_ready;
        prev_pix   = pixel;
        if (pixel_valid && first_pcyc < 0 && first_dcyc >= 0) first_pcyc = cyc;
        if (data_valid && data_ready && q_addr.size() > 0) begin
          if (first_dcyc < 0) first_dcyc = cyc;
          void'(q_addr.pop_front()); void'(q_due.pop_front());
        end
        if (addr_valid && addr_ready) begin
          iss_addr.push_back(addr);
          q_addr.push_back(addr);
          q_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
          f_issued++;
        end
        if (pixel_valid && pixel_ready) begin
          cap_pix.push_back(pixel); last_pix_cyc = cyc; f_xfer++;
        end
        tests++;
        if (q_addr.size() > DEPTH || f_issued - (f_xfer + 1) / 4 > DEPTH) begin
          fails++;
          $display("FAIL credit: outstanding=%0d issued=%0d pixels=%0d, required in-flight <= %0d",
                   q_addr.size(), f_issued, f_xfer, DEPTH);
        end
        if (done && !prev_done) done_cyc = cyc;
        prev_done = done;
      end
    end
  end

  task automatic test_reset;
    repeat (2) @(negedge clock);
    #3;
    tests++;
    if ({start_ack, done, addr_valid, data_ready, pixel_valid} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: ack,done,av,dr,pv=%b, required 00000",
               {start_ack, done, addr_valid, data_ready, pixel_valid});
    end
    tests++;
    if (pixel !== 8'h00 || addr !== 18'd0) begin
      fails++;
      $display("FAIL reset_data: pixel=%h addr=%h, required 00 / 00000", pixel, addr);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_frame(input logic sel, input int m, input string tag);
    logic        got;
    logic [17:0] base;
    base  = sel ? 18'd131072 : 18'd0;
    dmode = m;
    cap_pix.delete(); iss_addr.delete(); ack_cnt = 0;
    @(negedge clock);
    start = 1'b1; frame_sel = sel;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock); #3; got = start_ack;
    end
    start = 1'b0;
    tests++;
    if (!got) begin
      fails++; $display("FAIL %s start_ack: not seen within 20 cycles, required 1", tag);
    end
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clock); #3; got = done;
    end
    tests++;
    if (!got) begin
      fails++; $display("FAIL %s done: not seen within 4000 cycles, required 1", tag);
      return;
    end
    tests++;
    if (cap_pix.size() != NP) begin
      fails++; $display("FAIL %s pixel_count: got %0d, required %0d", tag, cap_pix.size(), NP);
    end
    for (int i = 0; i < cap_pix.size() && i < NP; i++) begin
      tests++;
      if (cap_pix[i] !== exp_pix(base, i, m)) begin
        fails++;
        $display("FAIL %s pixel[%0d]: got %h, required %h", tag, i, cap_pix[i], exp_pix(base, i, m));
      end
    end
    tests++;
    if (iss_addr.size() != NP / 4 || iss_addr[0] !== base || iss_addr[iss_addr.size()-1] !== base + 18'd3) begin
      fails++;
      $display("FAIL %s addr_range: n=%0d first=%0d last=%0d, required n=%0d first=%0d last=%0d",
               tag, iss_addr.size(), iss_addr[0], iss_addr[iss_addr.size()-1], NP / 4, base, base + 18'd3);
    end
    tests++;
    if (ack_cnt != 1) begin
      fails++; $display("FAIL %s ack_count: got %0d, required 1", tag, ack_cnt);
    end
    tests++;
    if (done_cyc != last_pix_cyc + 1) begin
      fails++;
      $display("FAIL %s done_timing: done at %0d, required %0d", tag, done_cyc, last_pix_cyc + 1);
    end
    tests++;
    if (first_pcyc != first_dcyc + 2) begin
      fails++;
      $display("FAIL %s latency: first pixel at %0d, required %0d", tag, first_pcyc, first_dcyc + 2);
    end
`ifdef FRAME_READER_CHECKSUM_EN
    begin
      logic [15:0] sum;
      sum = '0;
      for (int i = 0; i < NP; i++) sum = sum + 16'(exp_pix(base, i, m));
      tests++;
      if (checksum !== sum) begin
        fails++; $display("FAIL %s checksum: got %h, required %h", tag, checksum, sum);
      end
    end
`endif
    repeat (2) @(negedge clock);
    #3;
    tests++;
    if (done !== 1'b1 || pixel_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s done_hold: done=%b pv=%b, required done=1 pv=0", tag, done, pixel_valid);
    end
    done_ack = 1'b1;
    @(negedge clock);
    #3;
    done_ack = 1'b0;
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL %s done_clear: got %b, required 0", tag, done);
    end
  endtask

  task automatic test_random;
    pr_rand = 1; ar_rand = 1; spur = 1; lat_min = 1; lat_max = 6;
    for (int i = 0; i < 4; i++) test_frame(1'(i), 1, "rand");
    pr_rand = 0; ar_rand = 0; spur = 0; lat_min = 2; lat_max = 2;
  endtask

  task automatic test_start_overlap;
    logic got;
    dmode = 1; cap_pix.delete(); ack_cnt = 0;
    @(negedge clock);
    start = 1'b1; frame_sel = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clock); #3; got = done;
    end
    tests++;
    if (!got || ack_cnt != 1 || cap_pix.size() != NP) begin
      fails++;
      $display("FAIL overlap_frame: done=%b acks=%0d pixels=%0d, required 1/1/%0d",
               got, ack_cnt, cap_pix.size(), NP);
    end
    done_ack = 1'b1;
    @(negedge clock);
    #3;
    done_ack = 1'b0;
    tests++;
    if (start_ack !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL overlap_idle: start_ack=%b done=%b, required 0/0", start_ack, done);
    end
    @(negedge clock);
    #3;
    start = 1'b0;
    tests++;
    if (start_ack !== 1'b1 || ack_cnt != 2) begin
      fails++;
      $display("FAIL overlap_restart: start_ack=%b acks=%0d, required 1/2", start_ack, ack_cnt);
    end
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clock); #3; got = done;
    end
    tests++;
    if (!got) begin
      fails++; $display("FAIL overlap_second_done: not seen, required 1");
    end
    done_ack = 1'b1;
    @(negedge clock);
    #3;
    done_ack = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic got;
    logic saw_done;
    dmode = 0; cap_pix.delete();
    @(negedge clock);
    start = 1'b1; frame_sel = 1'b0;
    @(negedge clock);
    #3;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock); #3; got = (cap_pix.size() >= 5);
    end
    tests++;
    if (!got) begin
      fails++; $display("FAIL mid_progress: pixels=%0d, required >= 5", cap_pix.size());
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if ({start_ack, done, addr_valid, data_ready, pixel_valid} !== 5'b0 || pixel !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset_outputs: ack,done,av,dr,pv=%b pixel=%h, required 00000 / 00",
               {start_ack, done, addr_valid, data_ready, pixel_valid}, pixel);
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clock); #3; saw_done = saw_done | done;
    end
    tests++;
    if (saw_done !== 1'b0) begin
      fails++; $display("FAIL mid_no_done: done=%b after abort, required 0", saw_done);
    end
    test_frame(1'b0, 0, "after_reset");
  endtask

`ifdef FRAME_READER_CHECKSUM_EN
  task automatic test_checksum;
    logic got;
    dmode = 2;
    @(negedge clock);
    start = 1'b1; frame_sel = 1'b0;
    @(negedge clock);
    #3;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clock); #3; got = done;
    end
    repeat (3) @(negedge clock);
    #3;
    tests++;
    if (!got || done !== 1'b1 || checksum !== 16'h0FF0) begin
      fails++;
      $display("FAIL checksum_ff: done=%b checksum=%h, required 1 / 0ff0", done, checksum);
    end
    done_ack = 1'b1;
    @(negedge clock);
    #3;
    done_ack = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; frame_sel = 1'b0; done_ack = 1'b0;
    test_reset;
    test_frame(1'b0, 0, "frame0");
    test_frame(1'b1, 1, "frame1");
    test_random;
    test_start_overlap;
    test_reset_mid;
`ifdef FRAME_READER_CHECKSUM_EN
    test_checksum;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
